// File: rtl/random_square_ctrl_if.sv
// Position offer channel between the square sequencer and the pixel drawing stage.
interface random_square_ctrl_if;
    logic        pos_valid;
    logic        pos_ready;
    logic [4:0]  cell_x;
    logic [4:0]  cell_y;
    logic [11:0] xpos;
    logic [11:0] ypos;

    modport master (
        output pos_valid,
        output cell_x,
        output cell_y,
        output xpos,
        output ypos,
        input  pos_ready
    );

    modport slave (
        input  pos_valid,
        input  cell_x,
        input  cell_y,
        input  xpos,
        input  ypos,
        output pos_ready
    );
endinterface

// File: rtl/random_square_ctrl.sv
// Picks a new random grid cell every FRAMES_PER_MOVE frames from a free-running
// Galois LFSR and offers its pixel origin to the drawing stage via valid/ready.
module random_square_ctrl #(
    parameter int          CELL_SIZE       = 32,
    parameter int          CELLS_X         = 32,
    parameter int          CELLS_Y         = 24,
    parameter int          FRAMES_PER_MOVE = 60,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        vblnk,
    input  logic                        seed_load,
    input  logic [15:0]                 seed,
    output logic                        busy,
    random_square_ctrl_if.master        pos
);

    localparam int              SHIFT     = $clog2(CELL_SIZE);
    localparam int              CNT_W     = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_MOVE - 1);
    localparam logic [4:0]      X_LAST    = 5'(CELLS_X - 1);
    localparam logic [15:0]     LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAW,
        S_OFFER
    } state_t;

    state_t           state, state_n;
    logic [15:0]      lfsr, lfsr_shift;
    logic             vblnk_d;
    logic             frame_edge;
    logic [CNT_W-1:0] frame_cnt, frame_cnt_n;
    logic [2:0]       retry, retry_n;
    logic             force_pick, force_pick_n;
    logic [4:0]       cell_x, cell_y, cell_x_n, cell_y_n;
    logic [11:0]      xpos, ypos, xpos_n, ypos_n;
    logic [4:0]       next_x;
    logic [4:0]       cand_x, cand_y;
    logic             cand_ok;

    assign lfsr_shift = (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    assign frame_edge = vblnk & ~vblnk_d;

    // After eight straight rejects the candidate is the next column over, same row.
    assign next_x  = (cell_x == X_LAST) ? 5'd0 : cell_x + 5'd1;
    assign cand_x  = force_pick ? next_x : lfsr[4:0];
    assign cand_y  = force_pick ? cell_y : lfsr[9:5];
    assign cand_ok = (32'(cand_x) < CELLS_X) && (32'(cand_y) < CELLS_Y) &&
                     !((cand_x == cell_x) && (cand_y == cell_y));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr    <= LFSR_SEED;
            vblnk_d <= 1'b0;
        end else begin
            vblnk_d <= vblnk;
            if (seed_load) begin
                lfsr <= (seed == '0) ? 16'h0001 : seed;
            end else begin
                lfsr <= lfsr_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            frame_cnt  <= '0;
            retry      <= '0;
            force_pick <= 1'b0;
            cell_x     <= '0;
            cell_y     <= '0;
            xpos       <= '0;
            ypos       <= '0;
        end else begin
            state      <= state_n;
            frame_cnt  <= frame_cnt_n;
            retry      <= retry_n;
            force_pick <= force_pick_n;
            cell_x     <= cell_x_n;
            cell_y     <= cell_y_n;
            xpos       <= xpos_n;
            ypos       <= ypos_n;
        end
    end

    always_comb begin
        state_n      = state;
        frame_cnt_n  = frame_cnt;
        retry_n      = retry;
        force_pick_n = force_pick;
        cell_x_n     = cell_x;
        cell_y_n     = cell_y;
        xpos_n       = xpos;
        ypos_n       = ypos;

        case (state)
            S_IDLE: begin
                if (en) begin
                    state_n     = S_WAIT;
                    frame_cnt_n = '0;
                end
            end
            S_WAIT: begin
                if (frame_edge) begin
                    if (frame_cnt == CNT_LAST) begin
                        frame_cnt_n  = '0;
                        retry_n      = '0;
                        force_pick_n = 1'b0;
                        state_n      = S_DRAW;
                    end else begin
                        frame_cnt_n = frame_cnt + 1'b1;
                    end
                end
            end
            S_DRAW: begin
                if (force_pick || cand_ok) begin
                    cell_x_n     = cand_x;
                    cell_y_n     = cand_y;
                    xpos_n       = 12'(cand_x) << SHIFT;
                    ypos_n       = 12'(cand_y) << SHIFT;
                    retry_n      = '0;
                    force_pick_n = 1'b0;
                    state_n      = S_OFFER;
                end else if (retry == 3'd7) begin
                    force_pick_n = 1'b1;
                end else begin
                    retry_n = retry + 3'd1;
                end
            end
            S_OFFER: begin
                if (pos.pos_ready) begin
                    state_n = S_WAIT;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Disable wins over any pending accept or transfer; the last position is kept.
        if ((state != S_IDLE) && !en) begin
            state_n      = S_IDLE;
            frame_cnt_n  = '0;
            retry_n      = '0;
            force_pick_n = 1'b0;
            cell_x_n     = cell_x;
            cell_y_n     = cell_y;
            xpos_n       = xpos;
            ypos_n       = ypos;
        end
    end

    assign busy          = (state != S_IDLE);
    assign pos.pos_valid = (state == S_OFFER);
    assign pos.cell_x    = cell_x;
    assign pos.cell_y    = cell_y;
    assign pos.xpos      = xpos;
    assign pos.ypos      = ypos;

endmodule

// File: tb/tb_random_square_ctrl.sv
// Directed bench for random_square_ctrl: seeds chosen so every move lands on a
// hand-computed cell, including the eight-reject fallback path.
module tb_random_square_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        vblnk;
    logic        seed_load;
    logic [15:0] seed;
    logic        busy;

    int total = 0;
    int bad   = 0;

    random_square_ctrl_if pos ();

    random_square_ctrl #(
        .CELL_SIZE      (32),
        .CELLS_X        (32),
        .CELLS_Y        (24),
        .FRAMES_PER_MOVE(3),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .vblnk    (vblnk),
        .seed_load(seed_load),
        .seed     (seed),
        .busy     (busy),
        .pos      (pos)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int x, input int y, input int xp, input int yp);
        chk({tag, ".cell_x"}, 32'(pos.cell_x), x);
        chk({tag, ".cell_y"}, 32'(pos.cell_y), y);
        chk({tag, ".xpos"},   32'(pos.xpos),   xp);
        chk({tag, ".ypos"},   32'(pos.ypos),   yp);
    endtask

    // One-cycle vblnk pulse (optionally with a seed load on the same edge), then
    // watch `win` cycles and record the first cycle that shows pos_valid.
    task automatic pulse(input logic ld, input logic [15:0] sd, input int win,
                         output int first, output int nval,
                         output logic [4:0] cx, output logic [4:0] cy,
                         output logic [11:0] xp, output logic [11:0] yp);
        vblnk = 1'b1;
        seed_load = ld;
        seed = sd;
        tick();
        vblnk = 1'b0;
        seed_load = 1'b0;
        first = 0;
        nval = 0;
        cx = '0;
        cy = '0;
        xp = '0;
        yp = '0;
        for (int j = 1; j <= win; j++) begin
            tick();
            if (pos.pos_valid === 1'b1) begin
                if (nval == 0) begin
                    first = j;
                    cx = pos.cell_x;
                    cy = pos.cell_y;
                    xp = pos.xpos;
                    yp = pos.ypos;
                end
                nval++;
            end
        end
    endtask

    initial begin
        int          first, nval, m;
        logic [4:0]  cx, cy, px, py;
        logic [11:0] xp, yp;
        int          ex_x[3]     = '{5, 31, 0};
        int          ex_y[3]     = '{7, 4, 4};
        int          ex_first[3] = '{1, 1, 9};
        logic [15:0] ex_seed[3]  = '{16'h00E5, 16'h009F, 16'hFF20};

        rst = 1'b0;
        en = 1'b0;
        vblnk = 1'b0;
        seed_load = 1'b0;
        seed = '0;
        pos.pos_ready = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst.pos_valid", 32'(pos.pos_valid), 0);
        chk("rst.busy", 32'(busy), 0);
        chk_pos("rst", 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 chk("rst.lfsr", 32'(dut.lfsr), 32'h0000ACE1);
        tick();

        // Cadence: moves on the 3rd/6th/9th pulse; seeds pin each move's cell.
        en = 1'b1;
        pos.pos_ready = 1'b1;
        tick();
        chk("cad.busy_on", 32'(busy), 1);
        chk("cad.valid_idle", 32'(pos.pos_valid), 0);
        px = '0;
        py = '0;
        for (int p = 1; p <= 10; p++) begin
            m = (p / 3) - 1;
            if ((p % 3 == 0) && (p < 10)) begin
                pulse(1'b1, ex_seed[m], 14, first, nval, cx, cy, xp, yp);
                chk($sformatf("cad.p%0d.transfers", p), nval, 1);
                chk($sformatf("cad.p%0d.latency", p), first, ex_first[m]);
                chk($sformatf("cad.p%0d.cy_lt24", p), (cy < 5'd24) ? 1 : 0, 1);
                chk($sformatf("cad.p%0d.differs", p), ({cx, cy} != {px, py}) ? 1 : 0, 1);
                chk($sformatf("cad.p%0d.cx", p), 32'(cx), ex_x[m]);
                chk($sformatf("cad.p%0d.cy", p), 32'(cy), ex_y[m]);
                chk($sformatf("cad.p%0d.xpos", p), 32'(xp), ex_x[m] * 32);
                chk($sformatf("cad.p%0d.ypos", p), 32'(yp), ex_y[m] * 32);
                px = cx;
                py = cy;
            end else begin
                pulse(1'b0, 16'h0000, 14, first, nval, cx, cy, xp, yp);
                chk($sformatf("cad.p%0d.transfers", p), nval, 0);
            end
        end
        chk("cad.end_busy", 32'(busy), 1);
        chk("cad.end_valid", 32'(pos.pos_valid), 0);

        // Backpressure: offer (5,7) held for 50 cycles with frame edges arriving.
        pos.pos_ready = 1'b0;
        pulse(1'b0, 16'h0000, 3, first, nval, cx, cy, xp, yp);
        chk("bp.pre_transfers", nval, 0);
        pulse(1'b1, 16'h00E5, 1, first, nval, cx, cy, xp, yp);
        chk("bp.latency", first, 1);
        for (int i = 0; i < 50; i++) begin
            vblnk = (i % 10 == 0) ? 1'b1 : 1'b0;
            tick();
            chk($sformatf("bp.c%0d.valid", i), 32'(pos.pos_valid), 1);
            chk_pos($sformatf("bp.c%0d", i), 5, 7, 160, 224);
        end
        vblnk = 1'b0;
        pos.pos_ready = 1'b1;
        tick();
        chk("bp.xfer_valid", 32'(pos.pos_valid), 0);
        chk("bp.xfer_busy", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp.single%0d", i), 32'(pos.pos_valid), 0);
        end

        // Frames during the stall were not counted: two quiet pulses, move on the third.
        pulse(1'b0, 16'h0000, 12, first, nval, cx, cy, xp, yp);
        chk("stall.a", nval, 0);
        pulse(1'b0, 16'h0000, 12, first, nval, cx, cy, xp, yp);
        chk("stall.b", nval, 0);
        pulse(1'b1, 16'h0023, 4, first, nval, cx, cy, xp, yp);
        chk("stall.c_transfers", nval, 1);
        chk("stall.c_latency", first, 1);
        chk("stall.c_cx", 32'(cx), 3);
        chk("stall.c_cy", 32'(cy), 1);
        chk("stall.c_xpos", 32'(xp), 96);
        chk("stall.c_ypos", 32'(yp), 32);

        // Enable drop during DRAW (seed forces a long reject run).
        pulse(1'b0, 16'h0000, 3, first, nval, cx, cy, xp, yp);
        pulse(1'b0, 16'h0000, 3, first, nval, cx, cy, xp, yp);
        pulse(1'b1, 16'hFF20, 1, first, nval, cx, cy, xp, yp);
        chk("drop_draw.busy_before", 32'(busy), 1);
        chk("drop_draw.valid_before", 32'(pos.pos_valid), 0);
        en = 1'b0;
        tick();
        chk("drop_draw.busy", 32'(busy), 0);
        chk("drop_draw.valid", 32'(pos.pos_valid), 0);
        chk_pos("drop_draw", 3, 1, 96, 32);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("drop_draw.idle%0d", i), 32'(pos.pos_valid), 0);
        end
        chk_pos("drop_draw.hold", 3, 1, 96, 32);

        // Re-enable restarts the frame count from zero.
        en = 1'b1;
        tick();
        chk("reen.busy", 32'(busy), 1);
        pulse(1'b0, 16'h0000, 3, first, nval, cx, cy, xp, yp);
        chk("reen.g", nval, 0);
        en = 1'b0;
        tick();
        chk("reen.idle", 32'(busy), 0);
        en = 1'b1;
        tick();
        pulse(1'b0, 16'h0000, 12, first, nval, cx, cy, xp, yp);
        chk("reen.h", nval, 0);
        pulse(1'b0, 16'h0000, 12, first, nval, cx, cy, xp, yp);
        chk("reen.i", nval, 0);
        pos.pos_ready = 1'b0;
        pulse(1'b1, 16'h00E5, 1, first, nval, cx, cy, xp, yp);
        chk("reen.j_latency", first, 1);
        chk("reen.j_valid", 32'(pos.pos_valid), 1);
        chk_pos("reen.j", 5, 7, 160, 224);

        // Enable drop in OFFER with pos_ready high: no transfer, offer withdrawn.
        en = 1'b0;
        pos.pos_ready = 1'b1;
        tick();
        chk("drop_offer.valid", 32'(pos.pos_valid), 0);
        chk("drop_offer.busy", 32'(busy), 0);
        chk_pos("drop_offer", 5, 7, 160, 224);
        tick();
        chk("drop_offer.valid2", 32'(pos.pos_valid), 0);

        // Asynchronous reset in the middle of an offer.
        en = 1'b1;
        pos.pos_ready = 1'b0;
        tick();
        pulse(1'b0, 16'h0000, 2, first, nval, cx, cy, xp, yp);
        pulse(1'b0, 16'h0000, 2, first, nval, cx, cy, xp, yp);
        pulse(1'b1, 16'h0023, 1, first, nval, cx, cy, xp, yp);
        chk("arst.offer_valid", 32'(pos.pos_valid), 1);
        chk_pos("arst.offer", 3, 1, 96, 32);
        #1 rst = 1'b0;
        #1;
        chk("arst.valid", 32'(pos.pos_valid), 0);
        chk("arst.busy", 32'(busy), 0);
        chk_pos("arst", 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1 chk("arst.lfsr", 32'(dut.lfsr), 32'h0000ACE1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
